maple_txn_sequencer: RTL and testbench

- Sequences one Maple Bus transaction (command out, optional response in) around the existing transmitter, receiver and their FIFOs.
- Sits between the AXI-Lite control register block and the TX/RX datapath.
- Drives the ENABLE_TX, ENABLE_RX and RESET_RX controls that software previously toggled by hand.
- Applies turnaround and response timeouts, counts response bytes and reports a completion status.

---
 rtl/maple_pkg.sv | 32 +++
 rtl/maple_timeout_timer.sv | 32 +++
 rtl/maple_txn_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_maple_txn_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/maple_pkg.sv
// Shared definitions for the Maple Bus transaction sequencer.
//   state_e     : sequencer state encoding, also visible on state_dbg
//   STS_*       : completion status codes reported on status
//   *_DEF       : default timing and field widths
package maple_pkg;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_FLUSH      = 3'd1,
      ST_TX_START   = 3'd2,
      ST_TX_ACTIVE  = 3'd3,
      ST_TURNAROUND = 3'd4,
      ST_RX_WAIT    = 3'd5,
      ST_RX_ACTIVE  = 3'd6,
      ST_DONE       = 3'd7
   } state_e;

   localparam logic [2:0] STS_OK      = 3'd0;
   localparam logic [2:0] STS_NO_DATA = 3'd1;
   localparam logic [2:0] STS_TX_ERR  = 3'd2;
   localparam logic [2:0] STS_TIMEOUT = 3'd3;
   localparam logic [2:0] STS_RX_ERR  = 3'd4;
   localparam logic [2:0] STS_ABORTED = 3'd5;

   localparam int RST_CYC_DEF     = 4;
   localparam int TX_START_TO_DEF = 1024;
   localparam int TURN_CYC_DEF    = 16;
   localparam int RESP_TO_DEF     = 100000;   // 1 ms at 100 MHz
   localparam int TIMER_W_DEF     = 20;
   localparam int CNT_W_DEF       = 12;

endpackage

// File: rtl/maple_timeout_timer.sv
// Loadable down-counter shared by all timed sequencer states.
//   aclk, aresetn : clock, async active-low reset
//   load          : load load_val this edge (wins over counting)
//   load_val      : value to load
//   en            : count down while nonzero
//   expired       : counter is at zero
module maple_timeout_timer #(
   parameter int TIMER_W = 20
) (
   input  logic               aclk,
   input  logic               aresetn,
   input  logic               load,
   input  logic [TIMER_W-1:0] load_val,
   input  logic               en,
   output logic               expired
);

   logic [TIMER_W-1:0] count;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - TIMER_W'(1);
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/maple_txn_sequencer.sv
// Sequences one Maple Bus transaction (command out, optional response in)
// around the existing TX/RX datapath, replacing the software-driven
// ENABLE_TX / ENABLE_RX / RESET_RX toggling.
//   aclk, aresetn          : clock, async active-low reset
//   start, abort           : one-cycle requests from the control registers
//   expect_resp, flush_rx  : transaction options, sampled on start accept
//   tx_data_count          : TX FIFO occupancy
//   transmitting/receiving : transmitter busy / receiver in-packet flags
//   rx_tvalid/tready/tlast : monitored receiver-to-RX-FIFO stream
//   enable_tx, enable_rx   : datapath enables
//   reset_rx               : RX FIFO reset, active high
//   busy, done, status     : transaction progress and completion code
//   rx_byte_count          : response beats accepted in the last transaction
//   state_dbg              : current state encoding
//
// state         | meaning
// --------------+-----------------------------------------------------
// IDLE          | waiting for start
// FLUSH         | reset_rx held for RST_CYC cycles
// TX_START      | enable_tx up, waiting for transmitting to rise
// TX_ACTIVE     | command on the wire, waiting for transmitting to fall
// TURNAROUND    | both enables low for TURN_CYC cycles
// RX_WAIT       | enable_rx up, waiting for receiving to rise
// RX_ACTIVE     | counting response beats until tlast
// DONE          | one-cycle done pulse, status valid
module maple_txn_sequencer
   import maple_pkg::*;
#(
   parameter int RST_CYC     = RST_CYC_DEF,
   parameter int TX_START_TO = TX_START_TO_DEF,
   parameter int TURN_CYC    = TURN_CYC_DEF,
   parameter int RESP_TO     = RESP_TO_DEF,
   parameter int TIMER_W     = TIMER_W_DEF,
   parameter int CNT_W       = CNT_W_DEF
) (
   input  logic             aclk,
   input  logic             aresetn,
   input  logic             start,
   input  logic             abort,
   input  logic             expect_resp,
   input  logic             flush_rx,
   input  logic [CNT_W-1:0] tx_data_count,
   input  logic             transmitting,
   input  logic             receiving,
   input  logic             rx_tvalid,
   input  logic             rx_tready,
   input  logic             rx_tlast,
   output logic             enable_tx,
   output logic             enable_rx,
   output logic             reset_rx,
   output logic             busy,
   output logic             done,
   output logic [2:0]       status,
   output logic [CNT_W-1:0] rx_byte_count,
   output logic [2:0]       state_dbg
);

   state_e             state;
   state_e             state_nxt;
   logic [2:0]         fin;
   logic               exp_q;
   logic               accept;
   logic               beat;
   logic               tmr_load;
   logic               tmr_en;
   logic               tmr_exp;
   logic [TIMER_W-1:0] tmr_val;

   assign accept    = (state == ST_IDLE) && start && !abort;
   assign beat      = rx_tvalid && rx_tready;
   assign state_dbg = state;

   always_comb begin
      state_nxt = state;
      fin       = STS_OK;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (tx_data_count == '0) begin
                  state_nxt = ST_DONE;
                  fin       = STS_NO_DATA;
               end else if (flush_rx) begin
                  state_nxt = ST_FLUSH;
               end else begin
                  state_nxt = ST_TX_START;
               end
            end
         end
         ST_FLUSH: begin
            if (tmr_exp) state_nxt = ST_TX_START;
         end
         ST_TX_START: begin
            if (transmitting) begin
               state_nxt = ST_TX_ACTIVE;
            end else if (tmr_exp) begin
               state_nxt = ST_DONE;
               fin       = STS_TX_ERR;
            end
         end
         ST_TX_ACTIVE: begin
            if (!transmitting) state_nxt = exp_q ? ST_TURNAROUND : ST_DONE;
         end
         ST_TURNAROUND: begin
            if (tmr_exp) state_nxt = ST_RX_WAIT;
         end
         ST_RX_WAIT: begin
            if (receiving) begin
               state_nxt = ST_RX_ACTIVE;
            end else if (tmr_exp) begin
               state_nxt = ST_DONE;
               fin       = STS_TIMEOUT;
            end
         end
         ST_RX_ACTIVE: begin
            // a tlast beat beats both a dropped receiving flag and the timer
            if (beat && rx_tlast) begin
               state_nxt = ST_DONE;
            end else if (!receiving) begin
               state_nxt = ST_DONE;
               fin       = STS_RX_ERR;
            end else if (tmr_exp) begin
               state_nxt = ST_DONE;
               fin       = STS_TIMEOUT;
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
      if (abort && (state != ST_IDLE) && (state != ST_DONE)) begin
         state_nxt = ST_DONE;
         fin       = STS_ABORTED;
      end
   end

   // Timer is loaded on every state entry and on each response beat. A
   // window of N cycles loads N-1 because the zero cycle itself is the last
   // cycle spent in the state.
   always_comb begin
      tmr_load = (state_nxt != state) || ((state == ST_RX_ACTIVE) && beat);
      tmr_en   = (state != ST_IDLE) && (state != ST_DONE);
      tmr_val  = '0;
      case (state_nxt)
         ST_FLUSH:                tmr_val = TIMER_W'(RST_CYC - 1);
         ST_TX_START:             tmr_val = TIMER_W'(TX_START_TO - 1);
         ST_TURNAROUND:           tmr_val = TIMER_W'(TURN_CYC - 1);
         ST_RX_WAIT, ST_RX_ACTIVE: tmr_val = TIMER_W'(RESP_TO - 1);
         default:                 tmr_val = '0;
      endcase
   end

   maple_timeout_timer #(
      .TIMER_W (TIMER_W)
   ) u_timer (
      .aclk     (aclk),
      .aresetn  (aresetn),
      .load     (tmr_load),
      .load_val (tmr_val),
      .en       (tmr_en),
      .expired  (tmr_exp)
   );

   // Outputs are decoded from the next state so enables move on the same
   // edge as the state register (abort drops them immediately).
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state         <= ST_IDLE;
         enable_tx     <= 1'b0;
         enable_rx     <= 1'b0;
         reset_rx      <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         status        <= STS_OK;
         rx_byte_count <= '0;
         exp_q         <= 1'b0;
      end else begin
         state     <= state_nxt;
         enable_tx <= (state_nxt == ST_TX_START) || (state_nxt == ST_TX_ACTIVE);
         enable_rx <= (state_nxt == ST_RX_WAIT) || (state_nxt == ST_RX_ACTIVE);
         reset_rx  <= (state_nxt == ST_FLUSH);
         busy      <= (state_nxt != ST_IDLE);
         done      <= (state_nxt == ST_DONE);
         if (accept) begin
            exp_q         <= expect_resp;
            rx_byte_count <= '0;
         end else if ((state == ST_RX_ACTIVE) && beat && !abort
                      && (rx_byte_count != '1)) begin
            rx_byte_count <= rx_byte_count + CNT_W'(1);
         end
         if ((state_nxt == ST_DONE) && (state != ST_DONE)) status <= fin;
      end
   end

endmodule

// File: tb/tb_maple_txn_sequencer.sv
// Self-checking bench for maple_txn_sequencer. Each transaction is laid out
// on an absolute cycle schedule; expected edge times, status and byte count
// are computed from that schedule and compared with what a monitor records.
module tb_maple_txn_sequencer;
   import maple_pkg::*;

   localparam int RESP_TO_TB = 300;
   localparam int RST_TB     = 4;
   localparam int TXTO_TB    = 1024;
   localparam int TURN_TB    = 16;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        start = 1'b0, abort = 1'b0, expect_resp = 1'b0, flush_rx = 1'b0;
   logic [11:0] tx_data_count = '0;
   logic        transmitting = 1'b0, receiving = 1'b0;
   logic        rx_tvalid = 1'b0, rx_tready = 1'b0, rx_tlast = 1'b0;
   logic        enable_tx, enable_rx, reset_rx, busy, done;
   logic [2:0]  status, state_dbg;
   logic [11:0] rx_byte_count;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   int etx_rise, etx_fall, erx_rise, erx_fall, done_cyc, done_n, rst_hi;
   logic etx_q = 1'b0, erx_q = 1'b0;

   maple_txn_sequencer #(
      .RESP_TO (RESP_TO_TB)
   ) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .start         (start),
      .abort         (abort),
      .expect_resp   (expect_resp),
      .flush_rx      (flush_rx),
      .tx_data_count (tx_data_count),
      .transmitting  (transmitting),
      .receiving     (receiving),
      .rx_tvalid     (rx_tvalid),
      .rx_tready     (rx_tready),
      .rx_tlast      (rx_tlast),
      .enable_tx     (enable_tx),
      .enable_rx     (enable_rx),
      .reset_rx      (reset_rx),
      .busy          (busy),
      .done          (done),
      .status        (status),
      .rx_byte_count (rx_byte_count),
      .state_dbg     (state_dbg)
   );

   always #5 aclk = ~aclk;
   always @(posedge aclk) cyc <= cyc + 1;

   always @(negedge aclk) begin
      if (enable_tx && !etx_q) etx_rise = cyc;
      if (!enable_tx && etx_q) etx_fall = cyc;
      if (enable_rx && !erx_q) erx_rise = cyc;
      if (!enable_rx && erx_q) erx_fall = cyc;
      if (reset_rx) rst_hi++;
      if (done) begin
         done_cyc = cyc;
         done_n++;
      end
      etx_q = enable_tx;
      erx_q = enable_rx;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clear_rec();
      etx_rise = -1; etx_fall = -1; erx_rise = -1; erx_fall = -1;
      done_cyc = -1; done_n = 0; rst_hi = 0;
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge aclk);
   endtask

   // len==0: transmitter never starts; r<0: receiver never starts.
   // mode: 0 tlast on beat nb, 1 receiving drops, 2 abort, 3 beat gap timeout.
   task automatic run_txn(input int cnt, input bit exp, input bit fl, input int d,
                          input int len, input int r, input int nb, input int mode,
                          input bit poke);
      int a, t0, f, r0, bs, exp_done, exp_sts, exp_bytes, beats, guard;
      t0 = -1; f = -1; r0 = -1; exp_bytes = 0; exp_sts = STS_OK; exp_done = 0;
      @(negedge aclk);
      clear_rec();
      tx_data_count = 12'(cnt); expect_resp = exp; flush_rx = fl; start = 1'b1;
      @(negedge aclk);
      start = 1'b0;
      a = cyc;
      check_eq("busy_on_accept", busy, 1);
      if (cnt == 0) begin
         exp_done = a; exp_sts = STS_NO_DATA;
      end else begin
         t0 = a + (fl ? RST_TB : 0);
         wait_until(t0 + d);
         if (len == 0) begin
            exp_done = t0 + TXTO_TB; exp_sts = STS_TX_ERR;
         end else begin
            transmitting = 1'b1; start = poke;
            @(negedge aclk);
            start = 1'b0;
            wait_until(t0 + d + len);
            transmitting = 1'b0;
            f = t0 + d + len + 1;
            if (!exp) begin
               exp_done = f; exp_sts = STS_OK;
            end else begin
               r0 = f + TURN_TB;
               if (r < 0) begin
                  exp_done = r0 + RESP_TO_TB; exp_sts = STS_TIMEOUT;
               end else begin
                  wait_until(r0 + r);
                  receiving = 1'b1;
                  @(negedge aclk);
                  beats = 0; guard = 0;
                  while (beats < nb && guard < 500) begin
                     guard++;
                     rx_tvalid = ($urandom_range(0, 3) != 0);
                     rx_tready = ($urandom_range(0, 3) != 0);
                     rx_tlast  = (mode == 0) && (beats + 1 == nb) && rx_tvalid;
                     if (rx_tvalid && rx_tready) beats++;
                     @(negedge aclk);
                  end
                  rx_tvalid = 1'b0; rx_tready = 1'b0; rx_tlast = 1'b0;
                  bs = cyc; exp_bytes = beats;
                  case (mode)
                     0: begin exp_done = bs; exp_sts = STS_OK; end
                     1: begin receiving = 1'b0; exp_done = bs + 1; exp_sts = STS_RX_ERR; end
                     2: begin
                        abort = 1'b1;
                        @(negedge aclk);
                        abort = 1'b0;
                        exp_done = bs + 1; exp_sts = STS_ABORTED;
                     end
                     default: begin exp_done = bs + RESP_TO_TB; exp_sts = STS_TIMEOUT; end
                  endcase
               end
            end
         end
      end
      while (done_n == 0 && cyc <= exp_done + 4) @(negedge aclk);
      @(negedge aclk);
      receiving = 1'b0; transmitting = 1'b0;
      check_eq("done_time", done_cyc, exp_done);
      check_eq("done_pulses", done_n, 1);
      check_eq("status", status, exp_sts);
      check_eq("rx_byte_count", rx_byte_count, exp_bytes);
      check_eq("busy_after", busy, 0);
      check_eq("etx_rise", etx_rise, (cnt != 0) ? t0 : -1);
      check_eq("etx_fall", etx_fall, (cnt == 0) ? -1 : ((len != 0) ? f : exp_done));
      check_eq("erx_rise", erx_rise, r0);
      check_eq("erx_fall", erx_fall, (r0 >= 0) ? exp_done : -1);
      check_eq("reset_rx_cycles", rst_hi, (cnt != 0 && fl) ? RST_TB : 0);
      @(negedge aclk);
      check_eq("status_hold", status, exp_sts);
      check_eq("count_hold", rx_byte_count, exp_bytes);
   endtask

   initial begin
      int cnt, r;
      clear_rec();
      repeat (2) @(negedge aclk);
      check_eq("rst_enable_tx", enable_tx, 0);
      check_eq("rst_enable_rx", enable_rx, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_status", status, 0);
      check_eq("rst_state", state_dbg, 0);
      aresetn = 1'b1;
      @(negedge aclk);

      run_txn(5, 0, 0, 2, 38, 0, 0, 0, 1'b0);     // command only
      run_txn(0, 0, 0, 0, 0, 0, 0, 0, 1'b0);      // empty TX FIFO
      run_txn(7, 1, 0, 1, 10, 2, 12, 0, 1'b1);    // 12-beat response
      run_txn(4, 1, 0, 0, 5, -1, 0, 0, 1'b0);     // receiver never starts
      run_txn(3, 0, 0, 0, 0, 0, 0, 0, 1'b0);      // transmitter never starts
      run_txn(6, 1, 0, 0, 8, 1, 3, 2, 1'b0);      // abort after 3 beats
      run_txn(2, 0, 1, 0, 4, 0, 0, 0, 1'b0);      // flush before TX
      run_txn(9, 1, 1, 3, 6, 0, 5, 1, 1'b0);      // receiving drops
      run_txn(9, 1, 0, 0, 3, 4, 2, 3, 1'b0);      // beat gap timeout

      @(negedge aclk);
      tx_data_count = 12'd5; start = 1'b1; abort = 1'b1;
      @(negedge aclk);
      start = 1'b0; abort = 1'b0;
      check_eq("start_abort_busy", busy, 0);
      check_eq("start_abort_state", state_dbg, 0);

      for (int i = 0; i < 20; i++) begin
         cnt = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 4095);
         r   = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 5);
         run_txn(cnt, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 4), $urandom_range(1, 40), r,
                 $urandom_range(1, 12), $urandom_range(0, 3),
                 1'($urandom_range(0, 1)));
      end

      @(negedge aclk);
      tx_data_count = 12'd3; expect_resp = 1'b0; flush_rx = 1'b0; start = 1'b1;
      @(negedge aclk);
      start = 1'b0; transmitting = 1'b1;
      repeat (3) @(negedge aclk);
      check_eq("etx_before_reset", enable_tx, 1);
      #2 aresetn = 1'b0;
      #1;
      check_eq("etx_async_reset", enable_tx, 0);
      check_eq("busy_async_reset", busy, 0);
      check_eq("state_async_reset", state_dbg, 0);
      @(negedge aclk);
      transmitting = 1'b0; aresetn = 1'b1;
      @(negedge aclk);
      check_eq("state_after_reset", state_dbg, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
